// File: rtl/cache_bus_responder.sv
// Line-fill / writeback responder: splits one cache-line transaction into
// 2^LOGBWPL memory beats, assembling fetched beats into FetchBuffer.
module cache_bus_responder #(
  parameter int PA_BITS = 32,
  parameter int LINELEN = 512,
  parameter int BEATLEN = 64,
  parameter int LOGBWPL = $clog2(LINELEN / BEATLEN)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [1:0]           CacheBusRW,
  input  logic [PA_BITS-1:0]   CacheBusAdr,
  input  logic [BEATLEN-1:0]   CacheWriteBeat,
  output logic                 CacheBusAck,
  output logic [LOGBWPL-1:0]   BeatCount,
  output logic                 SelBusBeat,
  output logic [LINELEN-1:0]   FetchBuffer,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic [PA_BITS-1:0]   MemAdr,
  output logic [BEATLEN-1:0]   MemWData,
  input  logic                 MemReady,
  input  logic [BEATLEN-1:0]   MemRData
);

  localparam int BEAT_BYTES = BEATLEN / 8;

  typedef enum logic [1:0] {IDLE, WRITE, FETCH, DONE} state_t;

  state_t               state_q;
  logic [LOGBWPL-1:0]   beat_q;
  logic [LOGBWPL-1:0]   beat_d;
  logic [PA_BITS-1:0]   adr_q;
  logic [LINELEN-1:0]   fetch_q;
  logic                 req_q;
  logic                 wr_q;
  logic                 ack_q;
  logic                 last_beat;

  assign last_beat = &beat_q;
  // Counter wraps to zero on the final beat so IDLE always starts at beat 0.
  assign beat_d    = last_beat ? '0 : beat_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      adr_q   <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          beat_q <= '0;
          // Writeback wins over fetch so a dirty victim leaves before the refill.
          if (CacheBusRW[0]) begin
            state_q <= WRITE;
            adr_q   <= CacheBusAdr;
            req_q   <= 1'b1;
            wr_q    <= 1'b1;
          end else if (CacheBusRW[1]) begin
            state_q <= FETCH;
            adr_q   <= CacheBusAdr;
            req_q   <= 1'b1;
            wr_q    <= 1'b0;
          end
        end
        WRITE, FETCH: begin
          if (MemReady) begin
            beat_q <= beat_d;
            if (last_beat) begin
              state_q <= DONE;
              req_q   <= 1'b0;
              wr_q    <= 1'b0;
              ack_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          wr_q    <= 1'b0;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_q <= '0;
    end else if (state_q == FETCH && MemReady) begin
      fetch_q[int'(beat_q) * BEATLEN +: BEATLEN] <= MemRData;
    end
  end

  assign CacheBusAck = ack_q;
  assign BeatCount   = beat_q;
  assign SelBusBeat  = wr_q;
  assign FetchBuffer = fetch_q;
  assign MemReq      = req_q;
  assign MemWrite    = wr_q;
  assign MemAdr      = adr_q + PA_BITS'(beat_q) * PA_BITS'(BEAT_BYTES);
  assign MemWData    = CacheWriteBeat;

endmodule

// File: tb/tb_cache_bus_responder.sv
// Scoreboard bench for cache_bus_responder: stimulus queues expected beats and
// acks, a negedge monitor compares them as the DUT presents them.
module tb_cache_bus_responder;

  logic         clk;
  logic         resetn;
  logic [1:0]   CacheBusRW;
  logic [31:0]  CacheBusAdr;
  logic [63:0]  CacheWriteBeat;
  logic         CacheBusAck;
  logic [2:0]   BeatCount;
  logic         SelBusBeat;
  logic [511:0] FetchBuffer;
  logic         MemReq;
  logic         MemWrite;
  logic [31:0]  MemAdr;
  logic [63:0]  MemWData;
  logic         MemReady;
  logic [63:0]  MemRData;

  cache_bus_responder dut (
    .clk            (clk),
    .resetn         (resetn),
    .CacheBusRW     (CacheBusRW),
    .CacheBusAdr    (CacheBusAdr),
    .CacheWriteBeat (CacheWriteBeat),
    .CacheBusAck    (CacheBusAck),
    .BeatCount      (BeatCount),
    .SelBusBeat     (SelBusBeat),
    .FetchBuffer    (FetchBuffer),
    .MemReq         (MemReq),
    .MemWrite       (MemWrite),
    .MemAdr         (MemAdr),
    .MemWData       (MemWData),
    .MemReady       (MemReady),
    .MemRData       (MemRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Cache and memory models
  logic [31:0] rd_tag;
  logic        stall_en;
  logic [2:0]  stall_beat;
  int          stall_len;
  int          stall_cnt;

  assign CacheWriteBeat = 64'hA5 << BeatCount;
  assign MemRData       = {rd_tag, 29'd0, MemAdr[5:3]};
  assign MemReady       = !(stall_en && MemReq && (BeatCount == stall_beat) && (stall_cnt < stall_len));

  always @(posedge clk) begin
    if (!stall_en) stall_cnt <= 0;
    else if (MemReq && !MemReady) stall_cnt <= stall_cnt + 1;
  end

  typedef struct {
    bit          is_ack;
    int          beat;
    logic [31:0] adr;
    logic        wr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } exp_t;

  exp_t         sbq[$];
  logic [511:0] exp_buf;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endfunction

  function automatic void push_line(logic [31:0] base, logic wr, logic [31:0] tag);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.is_ack = 1'b0;
      e.beat   = k;
      e.adr    = base + 32'(8 * k);
      e.wr     = wr;
      e.wdata  = 64'hA5 << k;
      e.rdata  = {tag, 32'(k)};
      sbq.push_back(e);
    end
    e.is_ack = 1'b1;
    e.beat   = 0;
    e.adr    = '0;
    e.wr     = 1'b0;
    e.wdata  = '0;
    e.rdata  = '0;
    sbq.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      exp_buf = '0;
      sbq.delete();
    end else begin
      if (MemReq) begin
        if (sbq.size() == 0 || sbq[0].is_ack) begin
          chk("unexpected_beat", 512'(MemAdr), 512'(32'hFFFF_FFFF));
        end else begin
          e = sbq[0];
          chk("beat_idx", 512'(BeatCount), 512'(e.beat));
          chk("mem_adr", 512'(MemAdr), 512'(e.adr));
          chk("mem_write", 512'(MemWrite), 512'(e.wr));
          chk("sel_bus_beat", 512'(SelBusBeat), 512'(e.wr));
          chk("ack_low_in_beat", 512'(CacheBusAck), 512'd0);
          if (e.wr) chk("mem_wdata", 512'(MemWData), 512'(e.wdata));
          if (MemReady) begin
            if (!e.wr) exp_buf[64*e.beat +: 64] = e.rdata;
            void'(sbq.pop_front());
          end else if (!e.wr) begin
            chk("buf_slice_hold", 512'(FetchBuffer[64*e.beat +: 64]), 512'(exp_buf[64*e.beat +: 64]));
          end
        end
      end
      if (CacheBusAck) begin
        if (sbq.size() == 0 || !sbq[0].is_ack) begin
          chk("unexpected_ack", 512'(CacheBusAck), 512'd0);
        end else begin
          chk("ack_line", FetchBuffer, exp_buf);
          void'(sbq.pop_front());
        end
      end
    end
  end

  task automatic do_txn(input logic [1:0] rw, input logic [31:0] adr, input int exp_lat,
                        input int drop_at, input string nm);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    CacheBusAdr = adr;
    CacheBusRW  = rw;
    // n=1 is the IDLE cycle, so latency after the IDLE-exit edge is n-1.
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (CacheBusAck) got = 1'b1;
      else if (n == drop_at) begin
        @(posedge clk); #1;
        CacheBusRW  = 2'b00;
        CacheBusAdr = 32'hDEAD_BEE0;
      end
    end
    chk(nm, 512'(n - 1), 512'(exp_lat));
    @(posedge clk); #1;
    CacheBusRW = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  found;
    resetn      = 1'b0;
    CacheBusRW  = 2'b00;
    CacheBusAdr = '0;
    rd_tag      = '0;
    stall_en    = 1'b0;
    stall_beat  = 3'd0;
    stall_len   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 512'(CacheBusAck), 512'd0);
    chk("rst_memreq", 512'(MemReq), 512'd0);
    chk("rst_memwrite", 512'(MemWrite), 512'd0);
    chk("rst_selbeat", 512'(SelBusBeat), 512'd0);
    chk("rst_beatcount", 512'(BeatCount), 512'd0);
    chk("rst_fetchbuf", FetchBuffer, 512'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_memreq", 512'(MemReq), 512'd0);
    @(posedge clk); #1;

    // Basic fetch, slice k = k
    rd_tag = 32'h0;
    push_line(32'h8000_0040, 1'b0, 32'h0);
    do_txn(2'b10, 32'h8000_0040, 9, 0, "fetch_latency");

    // Writeback; FetchBuffer must keep the previous line
    push_line(32'h0000_1000, 1'b1, 32'h0);
    do_txn(2'b01, 32'h0000_1000, 9, 0, "wb_latency");

    // Both requested: writeback first, then the fetch from the IDLE after DONE
    rd_tag = 32'h2;
    push_line(32'h0000_3000, 1'b1, 32'h0);
    push_line(32'h0000_3000, 1'b0, 32'h2);
    do_txn(2'b11, 32'h0000_3000, 9, 0, "both_wb_latency");
    do_txn(2'b10, 32'h0000_3000, 9, 0, "both_fetch_latency");

    // Memory stalls three cycles at beat 4: 11 FETCH cycles, ack in the 12th
    rd_tag     = 32'h1;
    stall_en   = 1'b1;
    stall_beat = 3'd4;
    stall_len  = 3;
    push_line(32'h0000_4000, 1'b0, 32'h1);
    do_txn(2'b10, 32'h0000_4000, 12, 0, "stall_latency");
    stall_en = 1'b0;

    // Reset during beat 5 abandons the fetch
    rd_tag = 32'h3;
    push_line(32'h0000_5000, 1'b0, 32'h3);
    CacheBusAdr = 32'h0000_5000;
    CacheBusRW  = 2'b10;
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      @(negedge clk);
      n++;
      if (MemReq && BeatCount == 3'd5) found = 1'b1;
    end
    chk("rst_reach_beat5", 512'(found), 512'd1);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    CacheBusRW = 2'b00;
    @(negedge clk);
    chk("midrst_memreq", 512'(MemReq), 512'd0);
    chk("midrst_ack", 512'(CacheBusAck), 512'd0);
    chk("midrst_fetchbuf", FetchBuffer, 512'd0);
    chk("midrst_beatcount", 512'(BeatCount), 512'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    rd_tag = 32'h4;
    push_line(32'h0000_2000, 1'b0, 32'h4);
    do_txn(2'b10, 32'h0000_2000, 9, 0, "after_rst_latency");

    // Top-of-space line, request dropped and address changed during beat 2
    rd_tag = 32'h5;
    push_line(32'hFFFF_FFC0, 1'b0, 32'h5);
    do_txn(2'b10, 32'hFFFF_FFC0, 9, 3, "drop_latency");

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_memreq", 512'(MemReq), 512'd0);
    chk("queue_drained", 512'(sbq.size()), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
